// File: rtl/fp_mult_pkg.sv
// Shared constants and enumerations for the FP32 multiplier mantissa/exponent front end.
package fp_mult_pkg;

   localparam int FP_BIAS  = 127;
   localparam int EXP_W    = 8;
   localparam int MANT_W   = 23;
   localparam int PROD_W   = 48;
   localparam int EXPADD_W = 10;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORM,
      FP_INF,
      FP_NAN
   } fp_class_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

endpackage

// File: rtl/mult_operand_unpack.sv
// Splits an IEEE-754 single into sign, exponent and hidden-bit mantissa, and classifies it.
// Denormals are flushed to zero: their mantissa is forced to 0.
module mult_operand_unpack
   import fp_mult_pkg::*;
(
   input  logic [31:0]      op,
   output logic             sign,
   output logic [EXP_W-1:0] exp,
   output logic [MANT_W:0]  mant,
   output fp_class_e        cls
);

   logic [MANT_W-1:0] frac;

   assign sign = op[31];
   assign exp  = op[30:23];
   assign frac = op[22:0];

   // NOTE: every output gets a default before any branch, so no path can infer a latch.
   always_comb begin
      mant = {1'b1, frac};
      cls  = FP_NORM;
      if (exp == '0) begin
         mant = '0;
         cls  = FP_ZERO;
      end else if (exp == '1) begin
         cls = (frac != '0) ? FP_NAN : FP_INF;
      end
   end

endmodule

// File: rtl/mant_mult_seq.sv
// Iterative FP32 mantissa/exponent multiplier: shift-add product of the two 24-bit mantissas,
// BITS_PER_CYCLE multiplier bits per clock, plus biased exponent sum, sign and special-case flags.
module mant_mult_seq
   import fp_mult_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         a,
   input  logic [31:0]         b,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [PROD_W-1:0]   P,
   output logic [EXPADD_W-1:0] exp_add,
   output logic                sign,
   output logic                flag_zero,
   output logic                flag_inf,
   output logic                flag_nan,
   output logic                out_valid,
   input  logic                out_ready
);

   localparam int BPC    = BITS_PER_CYCLE;
   localparam int N      = (MANT_W + 1) / BPC;
   localparam int CNT_W  = $clog2(N + 1);
   localparam int SUM_W  = BPC + MANT_W + 2;
   localparam int WIDE_W = SUM_W + MANT_W + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

   logic              sign_a, sign_b;
   logic [EXP_W-1:0]  exp_a, exp_b;
   logic [MANT_W:0]   mant_a, mant_b;
   fp_class_e         cls_a, cls_b;

   state_e            state, state_n;
   logic [CNT_W-1:0]  step;
   logic [MANT_W:0]   ma;
   logic [MANT_W+1:0] hi;
   logic [MANT_W:0]   lo;

   logic                accept, last_step;
   logic [EXPADD_W-1:0] exp_sum;
   logic                any_nan, any_inf, any_zero, res_nan;
   logic [SUM_W-1:0]    partial;
   logic [WIDE_W-1:0]   wide;
   logic [MANT_W+1:0]   hi_next;
   logic [MANT_W:0]     lo_next;

   mult_operand_unpack u_unpack_a (.op(a), .sign(sign_a), .exp(exp_a), .mant(mant_a), .cls(cls_a));
   mult_operand_unpack u_unpack_b (.op(b), .sign(sign_b), .exp(exp_b), .mant(mant_b), .cls(cls_b));

   // in_ready stays low while reset is held; DONE hands straight over to the next operands.
   assign in_ready  = rst & ((state == IDLE) | ((state == DONE) & out_ready));
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;
   assign last_step = (step == LAST_STEP);

   always_comb begin
      exp_sum  = {2'b00, exp_a} + {2'b00, exp_b} - EXPADD_W'(FP_BIAS);
      any_nan  = (cls_a == FP_NAN)  | (cls_b == FP_NAN);
      any_inf  = (cls_a == FP_INF)  | (cls_b == FP_INF);
      any_zero = (cls_a == FP_ZERO) | (cls_b == FP_ZERO);
      res_nan  = any_nan | (any_inf & any_zero);
   end

   // One shift-add step: add the low multiplier bits times ma into hi, then shift {hi,lo} right.
   always_comb begin
      partial = SUM_W'(hi) + SUM_W'(lo[BPC-1:0]) * SUM_W'(ma);
      wide    = {partial, lo};
      hi_next = wide[WIDE_W-1 -: MANT_W+2];
      lo_next = wide[BPC+MANT_W -: MANT_W+1];
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (accept) state_n = CALC;
         CALC:    if (last_step) state_n = DONE;
         DONE:    if (out_ready) state_n = in_valid ? CALC : IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // NOTE: all datapath registers are reset too, so an aborted operation leaves nothing behind.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step      <= '0;
         ma        <= '0;
         hi        <= '0;
         lo        <= '0;
         P         <= '0;
         exp_add   <= '0;
         sign      <= 1'b0;
         flag_zero <= 1'b0;
         flag_inf  <= 1'b0;
         flag_nan  <= 1'b0;
      end else if (accept) begin
         step      <= '0;
         ma        <= mant_a;
         hi        <= '0;
         lo        <= mant_b;
         exp_add   <= exp_sum;
         sign      <= sign_a ^ sign_b;
         flag_nan  <= res_nan;
         flag_inf  <= ~res_nan & any_inf;
         flag_zero <= ~res_nan & ~any_inf & any_zero;
      end else if (state == CALC) begin
         step <= step + CNT_W'(1);
         hi   <= hi_next;
         lo   <= lo_next;
         if (last_step) P <= {hi_next[MANT_W:0], lo_next};
      end
   end

endmodule

// File: tb/tb_mant_mult_seq.sv
// Self-checking bench for mant_mult_seq: one DUT per BITS_PER_CYCLE in {1,2,4,8}, each driven with
// directed and random operands and compared every cycle against a plain-arithmetic product model.
module tb_mant_mult_seq;

   typedef struct {
      logic [47:0] p;
      logic [9:0]  e;
      logic        s;
      logic        z;
      logic        i;
      logic        n;
      int          due;
      bit          seen;
   } exp_t;

   localparam int NDIR = 6;
   localparam logic [31:0] DIR_A [NDIR] = '{32'h3FC00000, 32'h3FFFFFFF, 32'h00800000,
                                            32'h7F800000, 32'h7F800000, 32'h00000001};
   localparam logic [31:0] DIR_B [NDIR] = '{32'h3FC00000, 32'h3FFFFFFF, 32'h80800000,
                                            32'h00000000, 32'h3F800000, 32'h3F800000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Result from the number-format rules: product of the hidden-bit mantissas, biased exponent sum.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
      exp_t   r;
      int     ex, ey;
      longint mx, my;
      bit     zx, zy, ix, iy, nx, ny;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      mx = 0;
      my = 0;
      if (ex != 0) mx = longint'(x[22:0]) + 64'd8388608;
      if (ey != 0) my = longint'(y[22:0]) + 64'd8388608;
      zx = (ex == 0);
      zy = (ey == 0);
      ix = (ex == 255) && (x[22:0] == 0);
      iy = (ey == 255) && (y[22:0] == 0);
      nx = (ex == 255) && (x[22:0] != 0);
      ny = (ey == 255) && (y[22:0] != 0);
      r.n    = nx | ny | (ix & zy) | (iy & zx);
      r.i    = !r.n && (ix || iy);
      r.z    = !r.n && !r.i && (zx || zy);
      r.p    = 48'(mx * my);
      r.e    = 10'(ex + ey - 127);
      r.s    = x[31] ^ y[31];
      r.due  = 0;
      r.seen = 1'b0;
      return r;
   endfunction

   function automatic logic [31:0] rand_op();
      int          r;
      logic [7:0]  e;
      logic [22:0] f;
      r = $urandom_range(0, 9);
      f = 23'($urandom);
      if (r == 0) e = 8'h00;
      else if (r == 1) begin
         e = 8'hFF;
         if ($urandom_range(0, 1) == 0) f = '0;
      end else e = 8'($urandom_range(1, 254));
      return {1'($urandom), e, f};
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_bpc
      localparam int BPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8;
      localparam int N   = 24 / BPC;

      logic        rst;
      logic [31:0] a, b;
      logic        in_valid, in_ready, out_valid, out_ready;
      logic [47:0] P;
      logic [9:0]  exp_add;
      logic        sign, flag_zero, flag_inf, flag_nan;
      int          rdy_mode;
      int          cyc;
      bit          fin;
      string       tag;
      exp_t        q[$];

      mant_mult_seq #(.BITS_PER_CYCLE(BPC)) dut (
         .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
         .P(P), .exp_add(exp_add), .sign(sign), .flag_zero(flag_zero), .flag_inf(flag_inf),
         .flag_nan(flag_nan), .out_valid(out_valid), .out_ready(out_ready)
      );

      // rdy_mode: 0 always ready, 1 random, 2 stalled
      initial begin
         out_ready = 1'b0;
         forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 0) out_ready = 1'b1;
            else if (rdy_mode == 2) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 2) != 0);
         end
      end

      // Compare process: transfers are decided at the negedge before the edge that performs them.
      initial begin : compare
         exp_t m;
         cyc = 0;
         forever begin
            @(negedge clk);
            cyc++;
            if (!rst) q.delete();
            else begin
               if (q.size() > 0 && !q[0].seen && cyc == q[0].due)
                  check({tag, "_latency"}, 64'(out_valid), 64'd1);
               if (out_valid) begin
                  if (q.size() == 0) check({tag, "_spurious_valid"}, 64'(out_valid), 64'd0);
                  else begin
                     if (!q[0].seen) check({tag, "_valid_cycle"}, 64'(cyc), 64'(q[0].due));
                     q[0].seen = 1'b1;
                     if (!q[0].n && !q[0].i) check({tag, "_P"}, 64'(P), 64'(q[0].p));
                     check({tag, "_exp_add"}, 64'(exp_add), 64'(q[0].e));
                     check({tag, "_sign"}, 64'(sign), 64'(q[0].s));
                     check({tag, "_flags"}, 64'({flag_nan, flag_inf, flag_zero}),
                           64'({q[0].n, q[0].i, q[0].z}));
                     check({tag, "_in_ready_done"}, 64'(in_ready), 64'(out_ready));
                     if (out_ready) void'(q.pop_front());
                  end
               end else if (q.size() > 0) check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
               if (in_valid && in_ready) begin
                  m     = model(a, b);
                  m.due = cyc + N + 1;
                  q.push_back(m);
               end
            end
         end
      end

      task automatic send(input logic [31:0] x, input logic [31:0] y);
         bit got = 1'b0;
         a        = x;
         b        = y;
         in_valid = 1'b1;
         for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
         end
         check({tag, "_accept_wait"}, 64'(got), 64'd1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      endtask

      task automatic drain();
         bit empty = 1'b0;
         for (int k = 0; k < 400 && !empty; k++) begin
            @(negedge clk);
            #1;
            empty = (q.size() == 0) && !out_valid;
         end
         check({tag, "_drain"}, 64'(empty), 64'd1);
         @(posedge clk);
         #1;
      endtask

      initial begin : drive
         logic [47:0] p_hold;
         bit          got;
         int          nv;
         tag      = $sformatf("bpc%0d", BPC);
         fin      = 1'b0;
         rst      = 1'b0;
         a        = '0;
         b        = '0;
         in_valid = 1'b0;
         rdy_mode = 0;
         #3;
         check({tag, "_rst_out_valid"}, 64'(out_valid), 64'd0);
         check({tag, "_rst_in_ready"}, 64'(in_ready), 64'd0);
         check({tag, "_rst_P"}, 64'(P), 64'd0);
         check({tag, "_rst_exp_add"}, 64'(exp_add), 64'd0);
         check({tag, "_rst_flags"}, 64'({sign, flag_zero, flag_inf, flag_nan}), 64'd0);
         repeat (3) @(negedge clk);
         rst = 1'b1;
         #1;
         check({tag, "_in_ready_after_rst"}, 64'(in_ready), 64'd1);
         @(posedge clk);
         #1;

         for (int k = 0; k < NDIR; k++) begin
            send(DIR_A[k], DIR_B[k]);
            drain();
         end

         // Backpressure for 10 cycles with new operands waiting, then a same-cycle handover.
         rdy_mode = 2;
         send(32'h3FC00000, 32'h3FC00000);
         a        = 32'h40400000;
         b        = 32'hBF800000;
         in_valid = 1'b1;
         got      = 1'b0;
         for (int k = 0; k < N + 10 && !got; k++) begin
            @(negedge clk);
            got = out_valid;
         end
         check({tag, "_hs_first_result"}, 64'(got), 64'd1);
         p_hold = P;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, "_hold_out_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_P"}, 64'(P), 64'(p_hold));
         end
         rdy_mode = 0;
         got      = 1'b0;
         for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
         end
         check({tag, "_b2b_accept"}, 64'(got), 64'd1);
         check({tag, "_b2b_from_done"}, 64'(out_valid), 64'd1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         drain();

         // Reset half way through an operation: outputs clear at once and no result appears.
         send(32'h3FC00000, 32'h3FC00000);
         repeat (N / 2) @(posedge clk);
         #2;
         rst = 1'b0;
         #1;
         check({tag, "_midrst_out_valid"}, 64'(out_valid), 64'd0);
         check({tag, "_midrst_P"}, 64'(P), 64'd0);
         check({tag, "_midrst_exp_add"}, 64'(exp_add), 64'd0);
         check({tag, "_midrst_flags"}, 64'({sign, flag_zero, flag_inf, flag_nan}), 64'd0);
         @(negedge clk);
         @(posedge clk);
         #1;
         rst = 1'b1;
         #1;
         check({tag, "_midrst_in_ready"}, 64'(in_ready), 64'd1);
         nv = 0;
         repeat (N + 4) begin
            @(negedge clk);
            if (out_valid) nv++;
         end
         check({tag, "_midrst_no_result"}, 64'(nv), 64'd0);
         @(posedge clk);
         #1;

         rdy_mode = 1;
         for (int k = 0; k < 25; k++) begin
            send(rand_op(), rand_op());
            if ($urandom_range(0, 3) == 0) begin
               repeat (N + 3) @(posedge clk);
               #1;
            end
         end
         rdy_mode = 0;
         drain();
         fin = 1'b1;
      end
   end

   initial begin : main
      exp_t m;
      int   c;
      m = model(32'h3FC00000, 32'h3FC00000);
      check("pin_1p5_P", 64'(m.p), 64'h9000_0000_0000);
      check("pin_1p5_exp", 64'(m.e), 64'h07F);
      m = model(32'h3FFFFFFF, 32'h3FFFFFFF);
      check("pin_max_P", 64'(m.p), 64'hFFFF_FE00_0001);
      m = model(32'h00800000, 32'h80800000);
      check("pin_floor_P", 64'(m.p), 64'h4000_0000_0000);
      check("pin_floor_exp", 64'(m.e), 64'h383);
      check("pin_floor_sign", 64'(m.s), 64'd1);
      m = model(32'h7F800000, 32'h00000000);
      check("pin_inf_zero", 64'({m.n, m.i, m.z}), 64'b100);
      m = model(32'h7F800000, 32'h3F800000);
      check("pin_inf", 64'({m.n, m.i, m.z}), 64'b010);
      m = model(32'h00000001, 32'h3F800000);
      check("pin_denorm", 64'({m.n, m.i, m.z, m.p}), {3'b001, 48'd0});

      c = 0;
      while (c < 50000 && !(g_bpc[0].fin && g_bpc[1].fin && g_bpc[2].fin && g_bpc[3].fin)) begin
         @(posedge clk);
         c++;
      end
      check("all_instances_done", 64'({g_bpc[3].fin, g_bpc[2].fin, g_bpc[1].fin, g_bpc[0].fin}),
            64'hF);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
